// File: rtl/add_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_4_pkg
// Description : Shared constants for the registered ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package add_4_pkg;

    // Operand/sum width the adder is built and verified at.
    localparam int C_WIDTH_DEFAULT = 4;

    // Value driven on the registered carry-out while held in reset.
    localparam logic C_CO_RESET = 1'b0;

endpackage : add_4_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit combinational full adder, one link of the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the odd-parity of the three inputs.
    assign s  = a ^ b ^ ci;

    // Carry is the majority of the three inputs.
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder
`default_nettype wire

// File: rtl/add_4.sv
`default_nettype none
// ============================================================================
// Module      : add_4
// Description : Registered WIDTH-bit ripple-carry adder, {co,sum} = A+B+cin,
//               one result per clock with a single cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module add_4
    import add_4_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    // Ripple carry nets: w_carry[0] is the carry-in, w_carry[WIDTH] the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_co;

    assign w_carry[0] = cin;

    // One full adder per bit; each stage consumes the carry of the stage below.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            full_adder u_fa (
                .a  (A[gi]),
                .b  (B[gi]),
                .ci (w_carry[gi]),
                .s  (w_sum[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    // Capture the ripple result each edge; reset wins over a new capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_co  <= C_CO_RESET;
        end else begin
            r_sum <= w_sum;
            r_co  <= w_carry[WIDTH];
        end
    end

    assign sum = r_sum;
    assign co  = r_co;

endmodule : add_4
`default_nettype wire

// File: tb/tb_add_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_4
// Description : Self-checking bench for add_4 against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_4;

    logic       clk;
    logic       rst_n;
    logic       cin;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sum;
    logic       co;

    int n_tests;
    int n_fail;

    add_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cin   (cin),
        .A     (A),
        .B     (B),
        .sum   (sum),
        .co    (co)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 5-bit unsigned addition, zero while in reset.
    function automatic logic [4:0] model(input logic rn, input int a, input int b, input int c);
        int r;
        if (!rn) return 5'd0;
        r = a + b + c;
        return r[4:0];
    endfunction

    task automatic drive(input logic rn, input int a, input int b, input int c);
        rst_n = rn;
        A     = a[3:0];
        B     = b[3:0];
        cin   = c[0];
    endtask

    // Drive one operand set, clock it, compare 1 ns after the edge.
    task automatic step_check(input string name, input logic rn, input int a, input int b, input int c);
        logic [4:0] exp;
        drive(rn, a, b, c);
        exp = model(rn, a, b, c);
        @(posedge clk);
        #1;
        n_tests++;
        if ({co, sum} !== exp) begin
            n_fail++;
            $display("FAIL %s: A=%0d B=%0d cin=%0d rst_n=%0b got co=%0b sum=%0d want co=%0b sum=%0d",
                     name, a, b, c, rn, co, sum, exp[4], exp[3:0]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step_check("reset", 1'b0, 9, 9, 1);
    endtask

    task automatic test_basic();
        step_check("basic_3p4", 1'b1, 3, 4, 0);
    endtask

    task automatic test_carry_in();
        step_check("cin_0p0", 1'b1, 0, 0, 1);
        step_check("cin_15p0", 1'b1, 15, 0, 1);
    endtask

    task automatic test_overflow();
        step_check("ovf_max", 1'b1, 15, 15, 1);
        step_check("ovf_8p8", 1'b1, 8, 8, 0);
    endtask

    task automatic test_streaming();
        int a = 0;
        int b = 0;
        for (int i = 0; i < 20; i++) begin
            step_check("stream", 1'b1, a, b, 0);
            a = (a + 1) % 16;
            b = (b + 2) % 16;
        end
    endtask

    task automatic test_exhaustive();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    step_check("sweep", 1'b1, a, b, c);
    endtask

    // Inputs wiggling between edges must not disturb the registered outputs.
    task automatic test_between_edges();
        logic [4:0] exp;
        step_check("hold_base", 1'b1, 5, 6, 1);
        exp = model(1'b1, 5, 6, 1);
        drive(1'b1, 15, 15, 1);
        #2;
        n_tests++;
        if ({co, sum} !== exp) begin
            n_fail++;
            $display("FAIL hold_mid: got co=%0b sum=%0d want co=%0b sum=%0d", co, sum, exp[4], exp[3:0]);
        end
        step_check("hold_next", 1'b1, 2, 1, 0);
    endtask

    task automatic test_midstream_reset();
        int a = 4;
        int b = 7;
        for (int i = 0; i < 8; i++) begin
            step_check(i == 4 ? "mid_reset" : "mid_stream", (i == 4) ? 1'b0 : 1'b1, a, b, i % 2);
            a = (a + 1) % 16;
            b = (b + 2) % 16;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step_check("random", ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b0, 9, 9, 1);
        test_reset();
        test_basic();
        test_carry_in();
        test_overflow();
        test_streaming();
        test_exhaustive();
        test_between_edges();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_add_4
`default_nettype wire

// File: doc/add_4.md
ADD_4 -- requirements
Module: add_4

Interface
REQ-001 Parameter WIDTH, default 4, operand/sum width in bits; only 4 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cin  input  1  carry-in added to A+B.
REQ-005 A  input  4  unsigned operand A.
REQ-006 B  input  4  unsigned operand B.
REQ-007 sum  output  4  registered low 4 bits of A+B+cin.
REQ-008 co  output  1  registered carry-out (bit 4 of A+B+cin).

Function
REQ-009 The block SHALL compute the 5-bit unsigned result R = A + B + cin, with {co, sum} = R.
REQ-010 The result SHALL be produced by a 4-stage ripple-carry chain: stage i takes A[i], B[i], c[i] and gives s[i], c[i+1]; c[0] = cin; carry-out = c[4].
REQ-011 Each stage SHALL implement s = a^b^c and cout = (a&b)|(a&c)|(b&c).
REQ-012 sum and co SHALL be registered; latency is exactly 1 clock: inputs sampled at edge N appear on sum/co after edge N.
REQ-013 A new operand set SHALL be accepted every cycle (throughput 1/cycle); no handshake.
REQ-014 Wrap-around: for R >= 16, sum SHALL equal R-16 and co SHALL be 1; max case A=15, B=15, cin=1 gives sum=15, co=1.
REQ-015 Inputs that change between edges SHALL have no effect on outputs until the next rising edge.
REQ-016 No X SHALL appear on sum/co after the first edge with rst_n=1 and known inputs.

Reset
REQ-017 When rst_n=0 at a rising edge, sum SHALL become 4'h0 and co SHALL become 0.
REQ-018 Reset SHALL take priority over capture of a new result on the same edge.
REQ-019 Asserting rst_n=0 mid-stream SHALL discard the in-flight result; the first valid result after release is from inputs sampled at the first edge with rst_n=1.
REQ-020 Reset SHALL NOT be used asynchronously; rst_n SHALL appear only inside the clocked process.

Structure
REQ-021 No shared package is required; WIDTH is a module parameter local to add_4.
REQ-022 One sub-module, full_adder (ports a, b, ci, s, co), SHALL be instantiated WIDTH times to form the ripple chain.
REQ-023 The output register SHALL reside in add_4; full_adder SHALL be purely combinational.

Verification
REQ-024 Reset: rst_n=0 for 2 edges with A=9, B=9, cin=1 -> sum=0, co=0 while in reset.
REQ-025 Basic add: A=3, B=4, cin=0 -> one edge later sum=7, co=0.
REQ-026 Carry-in: A=0, B=0, cin=1 -> sum=1, co=0; A=15, B=0, cin=1 -> sum=0, co=1.
REQ-027 Overflow: A=15, B=15, cin=1 -> sum=15, co=1; A=8, B=8, cin=0 -> sum=0, co=1.
REQ-028 Streaming: A increments by 1 and B by 2 (mod 16) every cycle, cin=0 -> each cycle {co,sum} equals previous cycle's A+B; exhaustive 512-combination sweep with cin 0/1 matches reference model.
REQ-029 Mid-stream reset: rst_n=0 for one edge during streaming -> outputs 0 on that edge, correct results resume next edge.
